// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared definitions for the hardwired control unit: opcode
//               values, FSM state encoding, instruction classes and the
//               control-word bundle driven onto the DataPath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  // Opcode values held in IR[31:27]
  localparam logic [OP_W-1:0] OP_LDW  = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDWI = 5'b00001;
  localparam logic [OP_W-1:0] OP_STW  = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  // ALU code used for address and PC-relative computation
  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  // Bit positions of the one-hot instruction class vector
  localparam int CLS_RTYPE  = 0;
  localparam int CLS_IMM    = 1;
  localparam int CLS_MULDIV = 2;
  localparam int CLS_UNARY  = 3;
  localparam int CLS_LD     = 4;
  localparam int CLS_LDI    = 5;
  localparam int CLS_ST     = 6;
  localparam int CLS_BR     = 7;
  localparam int CLS_JR     = 8;
  localparam int CLS_JAL    = 9;
  localparam int CLS_MFHI   = 10;
  localparam int CLS_MFLO   = 11;
  localparam int CLS_IN     = 12;
  localparam int CLS_OUT    = 13;
  localparam int CLS_NOP    = 14;
  localparam int CLS_HALT   = 15;
  localparam int CLS_N      = 16;

  // Full control word presented to the DataPath
  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, hi_out, lo_out, mdr_out, inport_out;
    logic c_out, ba_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in;
    logic zin_high, zin_low, r_in, inc_pc;
    logic gra, grb, grc;
    logic read, write, con_in, outport_en;
    logic [OP_W-1:0] operation;
    logic run;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_opcode_class.sv
`default_nettype none
// ============================================================================
// Module      : opcode_class
// Description : Combinational opcode to one-hot instruction-class decoder.
//               Unlisted opcodes fall into the NOP class.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_class
  import cpu_defs::*;
(
  input  logic [OP_W-1:0]  opcode,
  output logic [CLS_N-1:0] cls
);

  // Map each opcode onto exactly one class bit
  always_comb begin
    cls = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:    cls[CLS_RTYPE]  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:         cls[CLS_IMM]    = 1'b1;
      OP_MUL, OP_DIV:                   cls[CLS_MULDIV] = 1'b1;
      OP_NEG, OP_NOT:                   cls[CLS_UNARY]  = 1'b1;
      OP_LDW:                           cls[CLS_LD]     = 1'b1;
      OP_LDWI:                          cls[CLS_LDI]    = 1'b1;
      OP_STW:                           cls[CLS_ST]     = 1'b1;
      OP_BR:                            cls[CLS_BR]     = 1'b1;
      OP_JR:                            cls[CLS_JR]     = 1'b1;
      OP_JAL:                           cls[CLS_JAL]    = 1'b1;
      OP_MFHI:                          cls[CLS_MFHI]   = 1'b1;
      OP_MFLO:                          cls[CLS_MFLO]   = 1'b1;
      OP_IN:                            cls[CLS_IN]     = 1'b1;
      OP_OUT:                           cls[CLS_OUT]    = 1'b1;
      OP_HALT:                          cls[CLS_HALT]   = 1'b1;
      default:                          cls[CLS_NOP]    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore control FSM for the DataPath. Fetches via
//               PC/MAR/MDR/IR, decodes IR[31:27] and sequences T3..T7.
//               Outputs decode combinationally from state, IR and CON_out.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int OP_W   = cpu_defs::OP_W
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              CON_out,
  output logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout,
  output logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, r_in, IncPC,
  output logic Gra, Grb, Grc,
  output logic Read, Write,
  output logic ConIn, outPortenable,
  output logic [OP_W-1:0] operation,
  output logic Run
);

  state_t           state, next_state;
  ctrl_t            c;
  logic [CLS_N-1:0] cls;
  logic [OP_W-1:0]  opcode;
  logic             unused_ir_bits;

  assign opcode         = IR[DATA_W-1 -: OP_W];
  assign unused_ir_bits = ^IR[DATA_W-OP_W-1:0];

  opcode_class u_opcode_class (
    .opcode (opcode),
    .cls    (cls)
  );

  // State register; clear restarts the fetch from T0
  always_ff @(posedge Clock) begin
    if (clear) state <= S_T0;
    else       state <= next_state;
  end

  // Control-word and next-state decode. The T2 decision for nop/halt reads
  // IR directly, so IR must already hold the new instruction in T2.
  always_comb begin
    c          = '0;
    next_state = S_T0;
    case (state)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1;
        c.zin_high = 1'b1; c.zin_low = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
        if (cls[CLS_HALT])     next_state = S_HALT;
        else if (cls[CLS_NOP]) next_state = S_T0;
        else                   next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        if (cls[CLS_RTYPE] || cls[CLS_IMM] || cls[CLS_LD] || cls[CLS_LDI] || cls[CLS_ST]) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end else if (cls[CLS_MULDIV]) begin
          c.gra = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end else if (cls[CLS_UNARY]) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.zin_high = 1'b1; c.zin_low = 1'b1;
          c.operation = opcode;
        end else if (cls[CLS_BR]) begin
          c.gra = 1'b1; c.ba_out = 1'b1; c.con_in = 1'b1;
        end else if (cls[CLS_JAL]) begin
          c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1;
        end else begin
          next_state = S_T0;
          c.gra        = 1'b1;
          c.pc_in      = cls[CLS_JR];
          c.ba_out     = cls[CLS_JR] | cls[CLS_OUT];
          c.outport_en = cls[CLS_OUT];
          c.hi_out     = cls[CLS_MFHI];
          c.lo_out     = cls[CLS_MFLO];
          c.inport_out = cls[CLS_IN];
          c.r_in       = cls[CLS_MFHI] | cls[CLS_MFLO] | cls[CLS_IN];
        end
      end
      S_T4: begin
        next_state = S_T5;
        if (cls[CLS_RTYPE] || cls[CLS_MULDIV]) begin
          c.grc = cls[CLS_RTYPE]; c.grb = cls[CLS_MULDIV]; c.ba_out = 1'b1;
          c.zin_high = 1'b1; c.zin_low = 1'b1; c.operation = opcode;
        end else if (cls[CLS_IMM]) begin
          c.c_out = 1'b1; c.zin_high = 1'b1; c.zin_low = 1'b1; c.operation = opcode;
        end else if (cls[CLS_LD] || cls[CLS_LDI] || cls[CLS_ST]) begin
          c.c_out = 1'b1; c.zin_high = 1'b1; c.zin_low = 1'b1; c.operation = ALU_ADD;
        end else if (cls[CLS_UNARY]) begin
          c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          next_state = S_T0;
        end else if (cls[CLS_BR]) begin
          c.pc_out = 1'b1; c.y_in = 1'b1;
        end else begin
          c.gra = 1'b1; c.ba_out = 1'b1; c.pc_in = cls[CLS_JAL];
          next_state = S_T0;
        end
      end
      S_T5: begin
        next_state = S_T6;
        if (cls[CLS_RTYPE] || cls[CLS_IMM] || cls[CLS_LDI]) begin
          c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          next_state = S_T0;
        end else if (cls[CLS_MULDIV]) begin
          c.zlow_out = 1'b1; c.lo_in = 1'b1;
        end else if (cls[CLS_LD] || cls[CLS_ST]) begin
          c.zlow_out = 1'b1; c.mar_in = 1'b1;
        end else begin
          c.c_out = cls[CLS_BR]; c.zin_high = cls[CLS_BR]; c.zin_low = cls[CLS_BR];
          c.operation = cls[CLS_BR] ? ALU_ADD : '0;
          next_state = cls[CLS_BR] ? S_T6 : S_T0;
        end
      end
      S_T6: begin
        next_state = S_T0;
        if (cls[CLS_MULDIV]) begin
          c.zhigh_out = 1'b1; c.hi_in = 1'b1;
        end else if (cls[CLS_LD]) begin
          c.read = 1'b1; c.mdr_in = 1'b1;
          next_state = S_T7;
        end else if (cls[CLS_ST]) begin
          c.gra = 1'b1; c.ba_out = 1'b1; c.mdr_in = 1'b1;
          next_state = S_T7;
        end else if (cls[CLS_BR]) begin
          c.zlow_out = CON_out; c.pc_in = CON_out;
        end
      end
      S_T7: begin
        c.mdr_out = cls[CLS_LD]; c.gra = cls[CLS_LD]; c.r_in = cls[CLS_LD];
        c.write   = cls[CLS_ST];
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_T0;
    endcase
    c.run = (state != S_HALT);
    if (clear) begin
      c     = '0;
      c.run = 1'b1;
    end
  end

  assign PCout = c.pc_out;       assign Zlowout = c.zlow_out;   assign Zhighout = c.zhigh_out;
  assign HIout = c.hi_out;       assign LOout = c.lo_out;       assign MDRout = c.mdr_out;
  assign In_Portout = c.inport_out; assign Cout = c.c_out;      assign Baout = c.ba_out;
  assign PCin = c.pc_in;         assign MARin = c.mar_in;       assign MDRin = c.mdr_in;
  assign IRin = c.ir_in;         assign Yin = c.y_in;           assign HIin = c.hi_in;
  assign LOin = c.lo_in;         assign Zin_high = c.zin_high;  assign Zin_low = c.zin_low;
  assign r_in = c.r_in;          assign IncPC = c.inc_pc;
  assign Gra = c.gra;            assign Grb = c.grb;            assign Grc = c.grc;
  assign Read = c.read;          assign Write = c.write;
  assign ConIn = c.con_in;       assign outPortenable = c.outport_en;
  assign operation = c.operation;
  assign Run = c.run;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. The driver issues
//               instructions and queues the per-cycle control vectors a
//               step-table reference model predicts; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  typedef logic [32:0] vec_t;

  // Bit positions in the bench's packed view of the DUT outputs
  localparam vec_t PCOUT = 33'h1 << 0,  ZLOW  = 33'h1 << 1,  ZHIGH = 33'h1 << 2;
  localparam vec_t HIOUT = 33'h1 << 3,  LOOUT = 33'h1 << 4,  MDROUT = 33'h1 << 5;
  localparam vec_t INPO  = 33'h1 << 6,  COUT  = 33'h1 << 7,  BAOUT = 33'h1 << 8;
  localparam vec_t PCIN  = 33'h1 << 9,  MARIN = 33'h1 << 10, MDRIN = 33'h1 << 11;
  localparam vec_t IRIN  = 33'h1 << 12, YIN   = 33'h1 << 13, HIIN  = 33'h1 << 14;
  localparam vec_t LOIN  = 33'h1 << 15, ZIN   = (33'h1 << 16) | (33'h1 << 17);
  localparam vec_t RIN   = 33'h1 << 18, INCPC = 33'h1 << 19, GRA   = 33'h1 << 20;
  localparam vec_t GRB   = 33'h1 << 21, GRC   = 33'h1 << 22, READ  = 33'h1 << 23;
  localparam vec_t WRITE = 33'h1 << 24, CONIN = 33'h1 << 25, OUTEN = 33'h1 << 26;
  localparam vec_t RUN   = 33'h1 << 32;
  localparam vec_t RESETV = RUN;
  localparam vec_t HALTV  = 33'h0;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        CON_out = 1'b0;
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout;
  logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, r_in, IncPC;
  logic Gra, Grb, Grc, Read, Write, ConIn, outPortenable, Run;
  logic [4:0] operation;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_out(CON_out),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout), .Baout(Baout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .Zin_high(Zin_high), .Zin_low(Zin_low), .r_in(r_in), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .ConIn(ConIn), .outPortenable(outPortenable), .operation(operation), .Run(Run)
  );

  always #5 Clock = ~Clock;

  vec_t act;
  assign act = {Run, operation, outPortenable, ConIn, Write, Read, Grc, Grb, Gra, IncPC,
                r_in, Zin_low, Zin_high, LOin, HIin, Yin, IRin, MDRin, MARin, PCin, Baout,
                Cout, In_Portout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout};

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  mq[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;

  function automatic vec_t st(input vec_t m, input logic [4:0] op);
    return m | (vec_t'(op) << 27) | RUN;
  endfunction

  // Reference model: the step list each instruction walks through
  function automatic void build(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    mq.delete();
    mq.push_back(st(PCOUT | MARIN | INCPC | ZIN, 5'd0));
    mq.push_back(st(ZLOW | PCIN | READ | MDRIN, 5'd0));
    mq.push_back(st(MDROUT | IRIN, 5'd0));
    if (op >= 5'd3 && op <= 5'd10) begin
      mq.push_back(st(GRB | BAOUT | YIN, 0));
      mq.push_back(st(GRC | BAOUT | ZIN, op));
      mq.push_back(st(ZLOW | GRA | RIN, 0));
    end else if (op >= 5'd11 && op <= 5'd13) begin
      mq.push_back(st(GRB | BAOUT | YIN, 0));
      mq.push_back(st(COUT | ZIN, op));
      mq.push_back(st(ZLOW | GRA | RIN, 0));
    end else if (op == 5'd14 || op == 5'd15) begin
      mq.push_back(st(GRA | BAOUT | YIN, 0));
      mq.push_back(st(GRB | BAOUT | ZIN, op));
      mq.push_back(st(ZLOW | LOIN, 0));
      mq.push_back(st(ZHIGH | HIIN, 0));
    end else if (op == 5'd16 || op == 5'd17) begin
      mq.push_back(st(GRB | BAOUT | ZIN, op));
      mq.push_back(st(ZLOW | GRA | RIN, 0));
    end else if (op <= 5'd2) begin
      mq.push_back(st(GRB | BAOUT | YIN, 0));
      mq.push_back(st(COUT | ZIN, 5'd3));
      if (op == 5'd1) mq.push_back(st(ZLOW | GRA | RIN, 0));
      else            mq.push_back(st(ZLOW | MARIN, 0));
      if (op == 5'd0) begin
        mq.push_back(st(READ | MDRIN, 0));
        mq.push_back(st(MDROUT | GRA | RIN, 0));
      end else if (op == 5'd2) begin
        mq.push_back(st(GRA | BAOUT | MDRIN, 0));
        mq.push_back(st(WRITE, 0));
      end
    end else begin
      case (op)
        5'd18: begin
          mq.push_back(st(GRA | BAOUT | CONIN, 0));
          mq.push_back(st(PCOUT | YIN, 0));
          mq.push_back(st(COUT | ZIN, 5'd3));
          mq.push_back(st(con ? (ZLOW | PCIN) : 33'h0, 0));
        end
        5'd19: mq.push_back(st(GRA | BAOUT | PCIN, 0));
        5'd20: begin
          mq.push_back(st(PCOUT | GRB | RIN, 0));
          mq.push_back(st(GRA | BAOUT | PCIN, 0));
        end
        5'd21: mq.push_back(st(INPO | GRA | RIN, 0));
        5'd22: mq.push_back(st(GRA | BAOUT | OUTEN, 0));
        5'd23: mq.push_back(st(HIOUT | GRA | RIN, 0));
        5'd24: mq.push_back(st(LOOUT | GRA | RIN, 0));
        default: ;
      endcase
    end
  endfunction

  task automatic expect_cycle(input vec_t v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Drive one instruction; abort_at >= 0 asserts clear in that step instead
  task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_at,
                           input int halt_cycles, input string tag);
    build(ir, con);
    for (int i = 0; i < mq.size(); i++) begin
      @(posedge Clock); #1;
      IR = ir; CON_out = con;
      if (i == abort_at) begin
        clear = 1'b1;
        expect_cycle(RESETV, {tag, "/abort"});
        return;
      end
      clear = 1'b0;
      expect_cycle(mq[i], $sformatf("%s/T%0d", tag, i));
    end
    if (ir[31:27] == 5'd26) begin
      repeat (halt_cycles) begin
        @(posedge Clock); #1;
        expect_cycle(HALTV, {tag, "/halted"});
      end
      @(posedge Clock); #1;
      clear = 1'b1;
      expect_cycle(RESETV, {tag, "/clear"});
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    forever begin
      @(negedge Clock);
      cyc++;
      if (exp_q.size() > 0) begin
        vec_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s cycle %0d: actual=%h required=%h", t, cyc, act, e);
        end
      end
    end
  end

  // Driver
  initial begin
    clear = 1'b1;
    repeat (2) begin
      @(posedge Clock); #1;
      expect_cycle(RESETV, "reset");
    end
    run_instr(32'h1A920000, 1'b0, -1, 0, "add");
    run_instr(32'h10800055, 1'b0, -1, 0, "stw");
    run_instr(32'h93080019, 1'b0, -1, 0, "br_nt");
    run_instr(32'h93080019, 1'b1, -1, 0, "br_t");
    run_instr(32'h71880000, 1'b0, -1, 0, "mul");
    run_instr(32'hD0000000, 1'b0, -1, 10, "halt");
    run_instr(32'h00880010, 1'b0, 6, 0, "ldw");
    run_instr(32'hC8000000, 1'b0, -1, 0, "nop");
    for (int n = 0; n < 80; n++) begin
      logic [31:0] r;
      logic        c;
      int          ab;
      r  = $urandom;
      c  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(r, c, ab, 3, $sformatf("rnd%0d_op%0d", n, r[31:27]));
    end
    @(posedge Clock); #1;
    clear = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore FSM that drives every control input of DataPath, replacing hand-sequenced testbench control.
- Fetches through PC/MAR/MDR/IR, decodes IR[31:27], then issues the per-instruction T3–T7 step sequence.
- Consumes IR and the CON flip-flop output; produces all register-enable, bus-select, memory and ALU-operation signals.

Parameters:
- DATA_W, 32, IR width
- OP_W, 5, opcode/operation width (IR[31:27])

Ports:
- Clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents from DataPath
- CON_out  in  1  branch-condition flip-flop output
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Baout  out  1 each  bus drivers
- PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, r_in, IncPC  out  1 each  register loads; "Zin" below means Zin_high=Zin_low=1
- Gra, Grb, Grc  out  1 each  register-field select
- Read, Write  out  1 each  memory strobes
- ConIn, outPortenable  out  1 each  CON FF load, out-port load
- operation  out  5  ALU code
- Run  out  1  1 while executing, 0 after halt

Behaviour:
- Clock and reset: single clock domain; clear is sampled on the rising edge.
- Reset: while clear=1, all outputs are forced to 0 except Run=1; operation=0. The state register loads T0 on the edge.
- Outputs are a pure decode of the state plus IR and CON_out. No glitch-latching. Each state lasts exactly one cycle.
- operation: equals the listed code only in Zin cycles; 00000 otherwise.
- States: T0..T7, HALT.
- Fetch, all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- R-type (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
  - T3: Grb, Baout, Yin.
  - T4: Grc, Baout, Zin, operation=opcode.
  - T5: Zlowout, Gra, r_in → T0.
- Immediate (addi 01011, andi 01100, ori 01101):
  - T3: Grb, Baout, Yin.
  - T4: Cout, Zin, operation=opcode.
  - T5: Zlowout, Gra, r_in → T0.
- mul 01110 / div 01111:
  - T3: Gra, Baout, Yin.
  - T4: Grb, Baout, Zin, operation=opcode.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin → T0.
- neg 10000 / not 10001:
  - T3: Grb, Baout, Zin, operation=opcode.
  - T4: Zlowout, Gra, r_in → T0.
- ldw 00000:
  - T3: Grb, Baout, Yin.
  - T4: Cout, Zin, operation=00011.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, r_in → T0.
- ldwi 00001: as ldw T3–T4, then T5: Zlowout, Gra, r_in → T0.
- stw 00010:
  - T3: Grb, Baout, Yin.
  - T4: Cout, Zin, operation=00011.
  - T5: Zlowout, MARin.
  - T6: Gra, Baout, MDRin (Read=0).
  - T7: Write → T0.
- branch 10010:
  - T3: Gra, Baout, ConIn.
  - T4: PCout, Yin.
  - T5: Cout, Zin, operation=00011.
  - T6: Zlowout and PCin only if CON_out=1; always → T0.
  - CON_out is sampled combinationally in T6.
- jr 10011: T3: Gra, Baout, PCin → T0.
- jal 10100:
  - T3: PCout, Grb, r_in (link register is the Rb field).
  - T4: Gra, Baout, PCin → T0.
- mfhi 10111: T3: HIout, Gra, r_in → T0.
- mflo 11000: T3: LOout, Gra, r_in → T0.
- in 10101: T3: In_Portout, Gra, r_in → T0.
- out 10110: T3: Gra, Baout, outPortenable → T0.
- nop 11001 and undefined 11011–11111: T2 → T0.
- halt 11010: T2 → HALT. In HALT all outputs are 0 and Run=0; only clear exits, to T0.
- IR is sampled by decode from T3 onward. IR changing mid-instruction is not guarded; IRin is asserted only in T2.
- clear mid-instruction: the sequence is aborted; the next state is T0 and no partial Write/r_in occurs in the clear cycle.

Decomposition:
- Package cpu_defs: opcode localparams (names as listed), state encodings, ALU_ADD=5'b00011.
- Sub-module opcode_class: combinational IR[31:27] → one-hot class (RTYPE, IMM, MULDIV, UNARY, LD, LDI, ST, BR, JR, JAL, MFHI, MFLO, IN, OUT, NOP, HALT).
- The FSM uses the class for next-state and output decode.

Test Plan:
- clear=1 for 2 cycles, then 0 → all outputs 0, Run=1; first cycle after release shows PCout=MARin=IncPC=Zin_high=Zin_low=1.
- IR=0x1A920000 (add R5,R2,R4):
  - T4: Grc=Baout=Zin=1, operation=00011.
  - T5: Zlowout=Gra=r_in=1.
  - T6 equals fetch T0 (6-cycle instruction).
- IR=0x10800055 (stw R1,0x55(R0)):
  - T6: Gra=Baout=MDRin=1, Read=0.
  - T7: Write=1, all others 0.
  - Then T0.
- IR=0x93080019 (branch R6):
  - CON_out=0 → T6 has PCin=0.
  - CON_out=1 → T6 has Zlowout=PCin=1.
  - Both cases return to T0.
- IR=0x71880000 (mul R3,R1):
  - T5: LOin=1.
  - T6: Zhighout=HIin=1, operation=00000.
  - Then T0.
- IR=0xD0000000 (halt):
  - After T2, Run=0 and all outputs stay 0 for 10 cycles.
  - clear pulse returns the FSM to T0 with Run=1.
  - clear asserted during ldw T6 → next cycle is T0 and r_in is never asserted.
